// File: rtl/forward_pkg.sv
// Shared widths, constants and the in-flight table entry for the forwarding scoreboard.
package forward_pkg;

    localparam int REGW   = 5;  // register number width
    localparam int TW     = 2;  // tnew / tuse width
    localparam int FWD_RF = 0;  // fwd_sel code meaning "take the register file value"

    // One in-flight instruction: does it write, which register, cycles until forwardable.
    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] wreg;
        logic [TW-1:0]   tnew;
    } entry_t;

    // Age tnew by one cycle, stopping at 0 once the result is forwardable.
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/forward_lookup.sv
// Checks one decode source operand against the in-flight table: finds the youngest
// writer of that register and decides between stalling, forwarding or using the RF.
module forward_lookup
    import forward_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int SW     = 2
) (
    input  entry_t          i_table [NSTAGE],  // index 0 is stage 1 (youngest)
    input  logic [REGW-1:0] i_addr,
    input  logic            i_used,
    input  logic [TW-1:0]   i_tuse,
    output logic            o_stall_req,
    output logic [SW-1:0]   o_sel
);

    logic            w_hit;
    logic [TW-1:0]   w_hit_tnew;
    logic [SW-1:0]   w_hit_stage;

    // Youngest match: scan oldest to youngest so the last hit (lowest stage) wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // through the block leaves it unassigned and a latch is never inferred.
        w_hit       = 1'b0;
        w_hit_tnew  = '0;
        w_hit_stage = '0;
        if (i_used && (i_addr != '0)) begin
            for (int s = NSTAGE - 1; s >= 0; s--) begin
                if (i_table[s].valid && (i_table[s].wreg == i_addr)) begin
                    w_hit       = 1'b1;
                    w_hit_tnew  = i_table[s].tnew;
                    w_hit_stage = SW'(s + 1);
                end
            end
        end
    end

    // Stall if the producer is not ready in time; forward only once it is ready now.
    always_comb begin
        o_stall_req = 1'b0;
        o_sel       = SW'(FWD_RF);
        if (w_hit) begin
            o_stall_req = (w_hit_tnew > i_tuse);
            if (w_hit_tnew == '0) begin
                o_sel = w_hit_stage;
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination registers, drives per-source
// forwarding selects and a zero-latency decode stall, and times the mult/div unit.
module forward_scoreboard
    import forward_pkg::*;
#(
    parameter int  NSTAGE = 3,
    parameter int  NSRC   = 2,
    parameter int  MD_LAT = 5,
    localparam int SW     = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REGW-1:0]      issue_wreg,
    input  logic [TW-1:0]        issue_tnew,
    input  logic [NSRC*REGW-1:0] src_addr,
    input  logic [NSRC-1:0]      src_used,
    input  logic [NSRC*TW-1:0]   src_tuse,
    input  logic                 md_start,
    input  logic                 md_use,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 md_busy
);

    localparam int CW = $clog2(MD_LAT + 1);

    entry_t          r_table [NSTAGE];
    logic [CW-1:0]   r_md_cnt;
    logic [NSRC-1:0] w_stall_req;

    // One lookup per decode source operand, all against the same table.
    for (genvar k = 0; k < NSRC; k++) begin : g_src
        forward_lookup #(
            .NSTAGE (NSTAGE),
            .SW     (SW)
        ) u_lookup (
            .i_table     (r_table),
            .i_addr      (src_addr[k*REGW +: REGW]),
            .i_used      (src_used[k]),
            .i_tuse      (src_tuse[k*TW +: TW]),
            .o_stall_req (w_stall_req[k]),
            .o_sel       (fwd_sel[k*SW +: SW])
        );
    end

    assign md_busy = (r_md_cnt != '0);
    assign stall   = (|w_stall_req) | (md_use & md_busy);

    // Advance the in-flight table every cycle; stage 1 takes decode or a bubble.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage reads the
        // pre-edge value of its neighbour, giving a true shift regardless of loop order.
        r_table[0].wreg <= issue_wreg;
        r_table[0].tnew <= issue_tnew;
        for (int s = 1; s < NSTAGE; s++) begin
            r_table[s].wreg <= r_table[s-1].wreg;
            r_table[s].tnew <= tnew_dec(r_table[s-1].tnew);
        end
        // NOTE: only the valid bits are reset; wreg/tnew are ignored while invalid, so
        // clearing them would cost reset fan-out for no behavioural difference.
        if (reset) begin
            for (int s = 0; s < NSTAGE; s++) begin
                r_table[s].valid <= 1'b0;
            end
        end else begin
            r_table[0].valid <= issue_valid & ~stall & (issue_wreg != '0);
            for (int s = 1; s < NSTAGE; s++) begin
                r_table[s].valid <= r_table[s-1].valid;
            end
        end
    end

    // Mult/div busy counter: load on an accepted start, then count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (md_start && !stall) begin
            r_md_cnt <= CW'(MD_LAT);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: a cycle-by-cycle vector table covering
// stall/forward/priority/reg-0 cases, plus hand sequences for mult/div and reset.
module tb_forward_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_wreg;
    logic [1:0]  issue_tnew;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic [3:0]  src_tuse;
    logic        md_start;
    logic        md_use;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic        md_busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       iv;
        logic [4:0] wreg;
        logic [1:0] tnew;
        logic [4:0] a0;
        logic [1:0] t0;
        logic [4:0] a1;
        logic [1:0] t1;
        logic [1:0] used;   // {src1, src0}
        logic       ms;
        logic       mu;
        logic       e_stall;
        logic [3:0] e_fwd;  // {sel1, sel0}
        logic       e_busy;
    } vec_t;

    forward_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wreg  (issue_wreg),
        .issue_tnew  (issue_tnew),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .src_tuse    (src_tuse),
        .md_start    (md_start),
        .md_use      (md_use),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string n, input logic rst, input logic iv, input logic [4:0] wreg,
        input logic [1:0] tnew, input logic [4:0] a0, input logic [1:0] t0,
        input logic [4:0] a1, input logic [1:0] t1, input logic [1:0] used,
        input logic ms, input logic mu, input logic es, input logic [3:0] ef,
        input logic eb);
        vec_t v;
        v.name = n; v.rst = rst; v.iv = iv; v.wreg = wreg; v.tnew = tnew;
        v.a0 = a0; v.t0 = t0; v.a1 = a1; v.t1 = t1; v.used = used;
        v.ms = ms; v.mu = mu; v.e_stall = es; v.e_fwd = ef; v.e_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs mid-period, then check the combinational outputs.
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset       = v.rst;
        issue_valid = v.iv;
        issue_wreg  = v.wreg;
        issue_tnew  = v.tnew;
        src_addr    = {v.a1, v.a0};
        src_tuse    = {v.t1, v.t0};
        src_used    = v.used;
        md_start    = v.ms;
        md_use      = v.mu;
        #1;
        check({v.name, ".stall"},   {3'b0, stall},   {3'b0, v.e_stall});
        check({v.name, ".fwd_sel"}, fwd_sel,         v.e_fwd);
        check({v.name, ".md_busy"}, {3'b0, md_busy}, {3'b0, v.e_busy});
    endtask

    vec_t vecs [15];

    initial begin
        //             name                 rst iv wreg tnew a0 t0 a1 t1 used  ms mu  es  fwd   eb
        vecs[0]  = mk("after_reset",        0, 0, 0, 0,  5, 0, 6, 0, 2'b11, 0, 0, 0, 4'h0, 0);
        vecs[1]  = mk("iss5_tnew1",         0, 1, 5, 1,  0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0);
        vecs[2]  = mk("raw_e_stall",        0, 1, 7, 0,  5, 0, 0, 0, 2'b01, 0, 0, 1, 4'h0, 0);
        vecs[3]  = mk("fwd_from_m",         0, 0, 0, 0,  5, 0, 0, 0, 2'b01, 0, 0, 0, 4'h2, 0);
        vecs[4]  = mk("fwd_from_w_both",    0, 1, 5, 0,  5, 0, 5, 0, 2'b11, 0, 0, 0, 4'hF, 0);
        vecs[5]  = mk("fwd_from_e",         0, 1, 5, 2,  5, 1, 0, 0, 2'b01, 0, 0, 0, 4'h1, 0);
        vecs[6]  = mk("youngest_e_wins",    0, 0, 0, 0,  5, 2, 0, 0, 2'b01, 0, 0, 0, 4'h0, 0);
        vecs[7]  = mk("youngest_m_wins",    0, 0, 0, 0,  5, 0, 5, 1, 2'b11, 0, 0, 1, 4'h0, 0);
        vecs[8]  = mk("fwd_w_issue_r0",     0, 1, 0, 2,  5, 0, 0, 0, 2'b01, 0, 0, 0, 4'h3, 0);
        vecs[9]  = mk("reg0_no_hazard",     0, 1, 9, 2,  0, 0, 0, 0, 2'b11, 0, 0, 0, 4'h0, 0);
        vecs[10] = mk("unused_src",         0, 0, 0, 0,  9, 0, 0, 0, 2'b10, 0, 0, 0, 4'h0, 0);
        vecs[11] = mk("src1_stall_m",       0, 0, 0, 0,  0, 0, 9, 0, 2'b10, 0, 0, 1, 4'h0, 0);
        vecs[12] = mk("src1_fwd_w_self",    0, 1, 9, 1,  0, 0, 9, 0, 2'b10, 0, 0, 0, 4'hC, 0);
        vecs[13] = mk("raw_e_md_start",     0, 0, 0, 0,  9, 0, 0, 0, 2'b01, 1, 0, 1, 4'h0, 0);
        vecs[14] = mk("md_start_ignored",   0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 0);

        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_wreg  = '0;
        issue_tnew  = '0;
        src_addr    = '0;
        src_used    = '0;
        src_tuse    = '0;
        md_start    = 1'b0;
        md_use      = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
        end

        // Mult/div: accepted start, five busy stall cycles, then released.
        apply(mk("md_start",            0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 4'h0, 0));
        for (int i = 0; i < 5; i++) begin
            apply(mk("md_wait",         0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 4'h0, 1));
        end
        apply(mk("md_done",             0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 4'h0, 0));

        // Reset in the middle of an md_busy stall with a pending hazard on $4.
        apply(mk("md_iss4",             0, 1, 4, 3, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'h0, 0));
        apply(mk("stall_at_reset",      1, 1, 6, 0, 4, 0, 4, 0, 2'b11, 1, 1, 1, 4'h0, 1));
        apply(mk("after_reset_clear",   0, 0, 0, 0, 4, 0, 6, 0, 2'b11, 0, 1, 0, 4'h0, 0));

        // Reset overrides an otherwise accepted issue and md_start in the same cycle.
        apply(mk("reset_with_issue",    1, 1, 6, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 4'h0, 0));
        apply(mk("issue_was_dropped",   0, 0, 0, 0, 6, 0, 6, 0, 2'b11, 0, 1, 0, 4'h0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter NSTAGE, default 3, is the number of tracked in-flight stages after decode (1 = E, 2 = M, 3 = W).
REQ-002 Parameter NSRC, default 2, is the number of decode source operands checked per cycle.
REQ-003 Parameter MD_LAT, default 5, is the mult/div busy cycles after start.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port issue_valid, input, 1 bit: decode holds a real instruction.
REQ-007 Port issue_wreg, input, 5 bits: destination register of the decode instruction.
REQ-008 Port issue_tnew, input, 2 bits: cycles after entering stage 1 until its result is forwardable.
REQ-009 Port src_addr, input, NSRC*5 bits: packed source register numbers.
REQ-010 Port src_used, input, NSRC bits: source k is actually read.
REQ-011 Port src_tuse, input, NSRC*2 bits: cycles until source k is consumed.
REQ-012 Port md_start, input, 1 bit: the decode instruction starts mult/div.
REQ-013 Port md_use, input, 1 bit: the decode instruction reads HI/LO or is a mult/div.
REQ-014 Port stall, output, 1 bit: freeze decode and bubble stage 1.
REQ-015 Port fwd_sel, output, NSRC*SW bits, SW = clog2(NSTAGE+1): 0 = register file, s = stage s.
REQ-016 Port md_busy, output, 1 bit: the mult/div counter is non-zero.

Function
REQ-017 The block SHALL hold a table of NSTAGE entries {valid, wreg, tnew}, where entry s is the instruction in stage s.
REQ-018 Each cycle, entries s >= 2 SHALL load entry s-1 with tnew decremented and saturating at 0, regardless of stall.
REQ-019 Entry 1 SHALL load {issue_valid & !stall & issue_wreg != 0, issue_wreg, issue_tnew} each cycle.
REQ-020 When stall = 1, entry 1 SHALL load a bubble (valid = 0).
REQ-021 A match for source k SHALL require: src_used[k] = 1, src_addr[k] != 0, entry valid, and wreg = src_addr[k].
REQ-022 The lowest-numbered (youngest) match SHALL be the only one considered for source k.
REQ-023 For source k, stall SHALL be requested if the youngest match has tnew > src_tuse[k].
REQ-024 fwd_sel[k] SHALL equal s if the youngest match in stage s has tnew = 0, and 0 otherwise, including when there is no match.
REQ-025 stall SHALL be the OR of all per-source requests and (md_use & md_busy); it is combinational with zero latency.
REQ-026 md_start & !stall SHALL load the counter with MD_LAT; otherwise a non-zero counter SHALL decrement by 1 per cycle.
REQ-027 md_start while stall = 1 SHALL be ignored.
REQ-028 The counter SHALL never wrap below 0.
REQ-029 Register 0 SHALL never cause a stall or a forward.
REQ-030 Decode reading a register that decode itself writes SHALL use older entries only.

Reset
REQ-031 reset = 1 at a clock edge SHALL clear every entry's valid bit and the md counter, overriding any issue or md_start in the same cycle.
REQ-032 After reset, stall SHALL be 0 and every fwd_sel field SHALL be 0 until a new issue occurs.
REQ-033 Reset during a stall or during a mult/div operation SHALL abandon that operation with no residual effect.

Structure
REQ-034 Package forward_pkg SHALL hold REGW = 5, TW = 2, the FWD_RF = 0 constant, and the entry struct typedef.
REQ-035 Sub-module forward_lookup (one source against the whole table, yielding stall_req and sel) SHALL be instantiated NSRC times.
REQ-036 The implementation SHALL contain no latches and no asynchronous logic.

Verification
REQ-037 Issue $5 with tnew = 1; next cycle decode reads $5 with tuse = 0 -> stall = 1 for one cycle; the following cycle stall = 0 and fwd_sel = 2.
REQ-038 Issue $5 with tnew = 0; next cycle decode reads $5 with tuse = 1 -> stall = 0 and fwd_sel = 1.
REQ-039 Issue $5, then issue $5 again; next cycle decode reads $5 -> the stage-1 entry wins the match.
REQ-040 Issue with wreg = $0 and tnew = 2, then read $0 -> stall = 0 and fwd_sel = 0.
REQ-041 md_start with MD_LAT = 5, then md_use -> stall = 1 for 5 cycles, then md_busy = 0 and stall = 0.
REQ-042 Assert reset during an md_busy stall -> the next cycle md_busy = 0, stall = 0, and all fwd_sel fields = 0.
